// File: rtl/z80_int_ctrl.sv
// ============================================================================
// z80_int_ctrl : Z80 IM2 interrupt controller (timer, 16550, external pin)
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_int_ctrl #(
  parameter int         TIMER_DIV = 480000,
  parameter logic [7:0] VEC_BASE  = 8'hF0,
  parameter logic [7:0] CTRL_PORT = 8'h20,
  parameter logic [7:0] EOI_PORT  = 8'h21
) (
  input  logic       CLK_24MHz,
  input  logic       RES,
  input  logic [7:0] A,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic       IORQ,
  input  logic       M1,
  input  logic       RD,
  input  logic       WR,
  input  logic       U_INT,
  input  logic       EXT_INT,
  output logic       INT
);

  localparam int                CNT_W    = $clog2(TIMER_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMER_DIV - 1);
  // Bit order {EXT_INT, U_INT, WR, RD, M1, IORQ}; idle levels on reset.
  localparam logic [5:0]        SYNC_RST = 6'b101111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_ACK     = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       meta_q, meta_d, sync_q, sync_d;
  logic             iorq_prev_q, iorq_prev_d;
  logic             rd_prev_q, rd_prev_d;
  logic             wr_prev_q, wr_prev_d;
  logic             ext_prev_q, ext_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mask_q, mask_d;
  logic             pend_tmr_q, pend_tmr_d;
  logic             pend_ext_q, pend_ext_d;
  logic             overrun_q, overrun_d;
  logic [2:0]       in_svc_q, in_svc_d;
  logic [1:0]       win_q, win_d;
  logic             stat_rd_q, stat_rd_d;
  logic             int_n_q, int_n_d;

  logic       iorq_s, m1_s, rd_s, wr_s, uint_s, ext_s;
  logic       io_write, ctrl_wr, eoi_wr, rd_rise, iorq_rise, ext_fall;
  logic       ack_cyc, stat_sel, tick;
  logic [2:0] pending, eff;
  logic [1:0] win_sel;
  logic [3:0] mask4, pend4;
  logic       ack_take, eoi_take;
  logic       vec_oe, stat_oe;
  logic [7:0] vector, status;
  logic       unused_d_in;

  assign unused_d_in = ^D_in[7:3];

  assign iorq_s = sync_q[0];
  assign m1_s   = sync_q[1];
  assign rd_s   = sync_q[2];
  assign wr_s   = sync_q[3];
  assign uint_s = sync_q[4];
  assign ext_s  = sync_q[5];

  assign io_write  = wr_prev_q & ~wr_s & ~iorq_s & m1_s;
  assign ctrl_wr   = io_write & (A == CTRL_PORT);
  assign eoi_wr    = io_write & (A == EOI_PORT);
  assign rd_rise   = ~rd_prev_q & rd_s;
  assign iorq_rise = ~iorq_prev_q & iorq_s;
  assign ext_fall  = ext_prev_q & ~ext_s;
  assign ack_cyc   = ~m1_s & ~iorq_s;
  assign stat_sel  = ~iorq_s & ~rd_s & m1_s & (A == CTRL_PORT);
  assign tick      = (cnt_q == CNT_LAST);

  assign pending = {pend_ext_q, uint_s, pend_tmr_q};
  assign eff     = pending & mask_q;
  assign mask4   = {1'b0, mask_q};
  assign pend4   = {1'b0, pending};
  assign win_sel = eff[0] ? 2'd0 : (eff[1] ? 2'd1 : 2'd2);

  // Datapath next-state: synchronisers, timer, mask and source bookkeeping.
  always_comb begin
    meta_d      = {EXT_INT, U_INT, WR, RD, M1, IORQ};
    sync_d      = meta_q;
    iorq_prev_d = iorq_s;
    rd_prev_d   = rd_s;
    wr_prev_d   = wr_s;
    ext_prev_d  = ext_s;
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    mask_d      = ctrl_wr ? D_in[2:0] : mask_q;

    stat_rd_d = stat_rd_q;
    if (stat_sel)
      stat_rd_d = 1'b1;
    else if (rd_s)
      stat_rd_d = 1'b0;

    // Set terms are applied last so a coincident tick/edge is never lost.
    pend_tmr_d = pend_tmr_q;
    if (ack_take && win_q == 2'd0)
      pend_tmr_d = 1'b0;
    if (tick)
      pend_tmr_d = 1'b1;

    pend_ext_d = pend_ext_q;
    if (ack_take && win_q == 2'd2)
      pend_ext_d = 1'b0;
    if (ext_fall)
      pend_ext_d = 1'b1;

    overrun_d = overrun_q;
    if (stat_rd_q && rd_rise)
      overrun_d = 1'b0;
    if (tick && pend_tmr_q)
      overrun_d = 1'b1;

    in_svc_d = in_svc_q;
    if (eoi_take)
      in_svc_d = 3'b000;
    if (ack_take)
      in_svc_d = in_svc_q | (3'b001 << win_q);
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ack_take = 1'b0;
    eoi_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eff) begin
          state_d = S_ASSERT;
          win_d   = win_sel;
        end
      end
      S_ASSERT: begin
        if (!(mask4[win_q] && pend4[win_q])) begin
          state_d = S_IDLE;
        end else if (ack_cyc) begin
          state_d  = S_ACK;
          ack_take = 1'b1;
        end
      end
      S_ACK: begin
        if (iorq_rise)
          state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (eoi_wr) begin
          state_d  = S_IDLE;
          eoi_take = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    int_n_d = (state_d != S_ASSERT);
  end

  always_ff @(posedge CLK_24MHz or posedge RES) begin
    if (RES) begin
      state_q     <= S_IDLE;
      meta_q      <= SYNC_RST;
      sync_q      <= SYNC_RST;
      iorq_prev_q <= 1'b1;
      rd_prev_q   <= 1'b1;
      wr_prev_q   <= 1'b1;
      ext_prev_q  <= 1'b1;
      cnt_q       <= '0;
      mask_q      <= 3'b000;
      pend_tmr_q  <= 1'b0;
      pend_ext_q  <= 1'b0;
      overrun_q   <= 1'b0;
      in_svc_q    <= 3'b000;
      win_q       <= 2'd0;
      stat_rd_q   <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      iorq_prev_q <= iorq_prev_d;
      rd_prev_q   <= rd_prev_d;
      wr_prev_q   <= wr_prev_d;
      ext_prev_q  <= ext_prev_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      pend_tmr_q  <= pend_tmr_d;
      pend_ext_q  <= pend_ext_d;
      overrun_q   <= overrun_d;
      in_svc_q    <= in_svc_d;
      win_q       <= win_d;
      stat_rd_q   <= stat_rd_d;
      int_n_q     <= int_n_d;
    end
  end

  // Bus drive comes from raw pins so the data is there before the synchronisers react.
  assign vec_oe  = ((state_q == S_ASSERT) || (state_q == S_ACK)) && !M1 && !IORQ;
  assign stat_oe = !IORQ && !RD && M1 && (A == CTRL_PORT);
  assign vector  = (VEC_BASE & 8'hF8) | {5'b00000, win_q, 1'b0};
  assign status  = {overrun_q, in_svc_q, 1'b0, pending};

  assign D_oe  = !RES && (vec_oe || stat_oe);
  assign D_out = RES     ? 8'h00  :
                 vec_oe  ? vector :
                 stat_oe ? status : 8'h00;
  assign INT   = int_n_q;

endmodule

`default_nettype wire

// File: tb/tb_z80_int_ctrl.sv
// ============================================================================
// tb_z80_int_ctrl : directed scoreboard bench for z80_int_ctrl
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_z80_int_ctrl;

  localparam int         DIV   = 100;
  localparam logic [7:0] CTRLP = 8'h20;
  localparam logic [7:0] EOIP  = 8'h21;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, d_in, d_out;
  logic       d_oe, iorq, m1, rd, wr, u_int, ext_int, int_n;

  int total = 0;
  int bad   = 0;
  int cyc;

  typedef struct {
    logic [7:0] val;
    logic [7:0] care;
  } exp_t;
  exp_t sb[$];

  z80_int_ctrl #(
    .TIMER_DIV(DIV),
    .VEC_BASE (8'hF0),
    .CTRL_PORT(CTRLP),
    .EOI_PORT (EOIP)
  ) dut (
    .CLK_24MHz(clk),
    .RES      (rst),
    .A        (a),
    .D_in     (d_in),
    .D_out    (d_out),
    .D_oe     (d_oe),
    .IORQ     (iorq),
    .M1       (m1),
    .RD       (rd),
    .WR       (wr),
    .U_INT    (u_int),
    .EXT_INT  (ext_int),
    .INT      (int_n)
  );

  always #5 clk = ~clk;

  // Reference timer phase: the pending timer bit rises on every multiple of DIV.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb.pop_front();
      check(tag, obs & e.care, e.val & e.care);
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    a = addr; d_in = data; iorq = 1'b0; wr = 1'b0;
    repeat (4) @(posedge clk);
    #1 wr = 1'b1; iorq = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic status_read(input string tag, input logic [7:0] val, input logic [7:0] care);
    sb.push_back('{val, care});
    @(posedge clk); #1;
    a = CTRLP; iorq = 1'b0; rd = 1'b0;
    @(negedge clk);
    check({tag, "_oe"}, {7'd0, d_oe}, 8'h01);
    sb_check(tag, d_out);
    repeat (3) @(posedge clk);
    #1 rd = 1'b1; iorq = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_int_low(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (int_n !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {7'd0, int_n}, 8'h00);
  endtask

  task automatic int_ack(input string tag, input logic [7:0] vec, input int budget);
    sb.push_back('{vec, 8'hFF});
    wait_int_low({tag, "_int"}, budget);
    @(posedge clk); #1 m1 = 1'b0;
    @(posedge clk); #1 iorq = 1'b0;
    @(negedge clk);
    check({tag, "_oe"}, {7'd0, d_oe}, 8'h01);
    sb_check(tag, d_out);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_int_rel"}, {7'd0, int_n}, 8'h01);
    @(posedge clk); #1 m1 = 1'b1; iorq = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic ext_pulse();
    @(posedge clk); #1 ext_int = 1'b0;
    repeat (3) @(posedge clk);
    #1 ext_int = 1'b1;
  endtask

  initial begin
    int  n;
    logic seen_low;

    rst = 1'b1; a = 8'h00; d_in = 8'h00;
    iorq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
    u_int = 1'b0; ext_int = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_int", {7'd0, int_n}, 8'h01);
    check("rst_oe", {7'd0, d_oe}, 8'h00);
    check("rst_dout", d_out, 8'h00);
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: timer source, status shows in-service timer only
    io_write(CTRLP, 8'h01);
    int_ack("t1_vec", 8'hF0, DIV + 2);
    status_read("t1_stat", 8'h10, 8'hFF);
    io_write(CTRLP, 8'h00);
    io_write(EOIP, 8'h00);

    // Test 2: UART level stays high across EOI; re-assert two cycles after EOI
    u_int = 1'b1;
    io_write(CTRLP, 8'h02);
    int_ack("t2_vec1", 8'hF2, 20);
    @(posedge clk); #1 a = EOIP; d_in = 8'h5A; iorq = 1'b0; wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t2_eoi_idle", {7'd0, int_n}, 8'h01);
    @(negedge clk);
    check("t2_reassert", {7'd0, int_n}, 8'h00);
    @(posedge clk); #1 wr = 1'b1; iorq = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    int_ack("t2_vec2", 8'hF2, 10);
    u_int = 1'b0;
    repeat (3) @(posedge clk);
    io_write(EOIP, 8'h00);
    io_write(CTRLP, 8'h00);

    // Test 3: timer beats UART; align just after a timer tick
    n = 0;
    @(negedge clk);
    while ((cyc % DIV) != 2 && n < 3 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("t3_align", {7'd0, ((cyc % DIV) == 2)}, 8'h01);
    u_int = 1'b1;
    io_write(CTRLP, 8'h07);
    int_ack("t3_vec_tmr", 8'hF0, 20);
    io_write(EOIP, 8'h00);
    int_ack("t3_vec_uart", 8'hF2, 20);
    u_int = 1'b0;
    repeat (3) @(posedge clk);
    io_write(EOIP, 8'h00);
    seen_low = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (int_n !== 1'b1) seen_low = 1'b1;
    end
    check("t3_quiet", {7'd0, seen_low}, 8'h00);
    io_write(CTRLP, 8'h00);

    // Test 4: external edge, second edge latched during service
    io_write(CTRLP, 8'h04);
    ext_pulse();
    int_ack("t4_vec1", 8'hF4, 20);
    status_read("t4_ext_clr", 8'h40, 8'h7C);
    ext_pulse();
    repeat (4) @(posedge clk);
    status_read("t4_ext_latch", 8'h44, 8'h7C);
    @(negedge clk);
    check("t4_no_nest", {7'd0, int_n}, 8'h01);
    io_write(EOIP, 8'h00);
    int_ack("t4_vec2", 8'hF4, 20);
    io_write(EOIP, 8'h00);
    io_write(CTRLP, 8'h00);

    // Test 5: overrun after two unacknowledged ticks, cleared by the read
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (cyc < 2 * DIV + 5 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    status_read("t5_ovr", 8'h81, 8'hFF);
    status_read("t5_ovr_clr", 8'h01, 8'hFF);

    // Test 6: reset in the middle of an acknowledge
    io_write(CTRLP, 8'h01);
    wait_int_low("t6_int", 20);
    sb.push_back('{8'hF0, 8'hFF});
    @(posedge clk); #1 m1 = 1'b0;
    @(posedge clk); #1 iorq = 1'b0;
    n = 0;
    @(negedge clk);
    while (int_n !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_ack", {7'd0, int_n}, 8'h01);
    check("t6_oe_pre", {7'd0, d_oe}, 8'h01);
    sb_check("t6_vec", d_out);
    #2 rst = 1'b1;
    #1;
    check("t6_oe_rst", {7'd0, d_oe}, 8'h00);
    check("t6_int_rst", {7'd0, int_n}, 8'h01);
    check("t6_dout_rst", d_out, 8'h00);
    m1 = 1'b1; iorq = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen_low = 1'b0;
    repeat (2 * DIV + 50) begin
      @(negedge clk);
      if (int_n !== 1'b1) seen_low = 1'b1;
    end
    check("t6_masked", {7'd0, seen_low}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/z80_int_ctrl.md
Name: z80_int_ctrl

Overview:
- Z80 IM2 interrupt controller inside the z80bd CPLD.
- Arbitrates three requesters onto the single active-low INT line: the periodic frame timer, the 16550 (U_INT) and an external pin.
- Supplies the IM2 vector during the interrupt-acknowledge cycle.
- Is configured and serviced through two Z80 I/O ports, decoded from A[7:0] in the same way as the page ports 0x10/0x11.

Parameters:
- TIMER_DIV, 480000: CLK_24MHz cycles per timer tick (50 Hz).
- VEC_BASE, 8'hF0: IM2 vector base; bits 2:0 are forced by hardware.
- CTRL_PORT, 8'h20: mask write / status read port.
- EOI_PORT, 8'h21: end-of-interrupt port; any written data value is accepted.

Ports:
- CLK_24MHz  in  1  main clock
- RES  in  1  asynchronous reset, active-high (top level inverts the board reset)
- A  in  8  Z80 A[7:0]
- D_in  in  8  Z80 data bus, inbound
- D_out  out  8  data driven to the Z80
- D_oe  out  1  D_out enable; the top level tri-states D with this
- IORQ  in  1  active-low
- M1  in  1  active-low
- RD  in  1  active-low
- WR  in  1  active-low
- U_INT  in  1  16550 interrupt, active-high, level
- EXT_INT  in  1  external request, active-low, falling-edge
- INT  out  1  Z80 INT, active-low

Behaviour:

Reset (asynchronous, RES=1):
- State IDLE.
- mask=3'b000.
- pending, in-service and overrun cleared.
- Timer counter = 0.
- INT=1, D_oe=0, D_out=8'h00.
- Reset mid-acknowledge aborts immediately; D_oe drops in the same instant.

Synchronisation:
- IORQ, M1, RD, WR, U_INT and EXT_INT pass through 2-flop synchronisers.
- Edges are detected on the synchronised copies.

Port write:
- A port write is the falling edge of synced WR while synced IORQ=0 and synced M1=1.
- Write to CTRL_PORT: mask <= D_in[2:0], with bit0=timer, bit1=UART, bit2=ext.
- Write to EOI_PORT: clears in-service and returns the FSM from SERVICE to IDLE.
- An EOI in any other state is ignored.

Status read (CTRL_PORT):
- D_oe = !IORQ & !RD & M1 & (A==CTRL_PORT), combinational from the raw pins.
- D_out = {overrun, in_service[2:0], 1'b0, pending[2:0]}.
- The rising edge of synced RD that ends this read clears overrun.

Sources:
- Timer: the counter counts 0..TIMER_DIV-1 and wraps. At the wrap it sets pend_tmr. If pend_tmr is already 1 it also sets overrun. The counter runs in every state.
- UART: pend_uart = synced U_INT (level); it is cleared only by the source.
- Ext: a synced falling edge sets pend_ext.
- pend_tmr and pend_ext are cleared on acknowledge of that source.
- Effective request = pending & mask.

Arbitration:
- Fixed priority: timer > UART > ext.
- The winner id (0, 1, 2) is latched on entering ASSERT and frozen until IDLE.

FSM:
- IDLE: any effective request goes to ASSERT next cycle; INT=0 from that cycle.
- ASSERT:
  - INT=0.
  - If the winner's mask bit or pending bit clears before acknowledge, go to IDLE and set INT=1.
  - Acknowledge (synced M1=0 & IORQ=0) goes to ACK. On entry to ACK: INT=1, in_service[winner]=1, and the winner's edge-pending bit is cleared.
- ACK:
  - D_oe = !M1 & !IORQ (raw pins).
  - D_out = VEC_BASE & 8'hF8 | {winner,1'b0}.
  - D_oe is also asserted combinationally during ASSERT whenever raw M1 and IORQ are both low, so the vector appears before the synchronisers catch up.
  - Synced IORQ rising goes to SERVICE.
- SERVICE:
  - INT held at 1.
  - No nesting: new requests stay pending.
  - EOI goes to IDLE.
  - If a request is still effective, ASSERT follows one cycle after IDLE.

Simultaneous events:
- A tick and an EOI in the same cycle: both take effect.
- A tick on the acknowledge-clear cycle of the timer: pend_tmr stays 1 and overrun is set.
- A write to CTRL_PORT during ACK or SERVICE updates the mask only; the current service is unaffected.

Test Plan:
1. Reset then write 0x20 <- 0x01 with TIMER_DIV=100 -> INT=0 within 100+2 cycles. The IM2 acknowledge drives vector 0xF0 with D_oe=1. INT=1 after the acknowledge. Status read gives 0x10.
2. U_INT=1, mask=0x02, ack, then write 0x21 while U_INT still =1 -> first vector 0xF2. INT re-asserts 2 cycles after EOI. The second vector is again 0xF2.
3. Timer and UART pending together, mask=0x07 -> vector 0xF0 first. After EOI the next vector is 0xF2. After U_INT=0 and EOI, INT stays 1.
4. EXT_INT pulse low for 3 cycles, mask=0x04 -> vector 0xF4. pend_ext is cleared. A second pulse during SERVICE is latched and served after EOI.
5. Timer with no ack for 2×TIMER_DIV -> status bit7=1. The read returns 0x81 (overrun, pend_tmr). A second status read returns 0x01.
6. Assert RES during ACK with raw M1=IORQ=0 -> D_oe=0 and INT=1 immediately. mask=0, so no INT after release.
